udp_filter_csr_slave: RTL and testbench
=======================================

Name: udp_filter_csr_slave

Overview:
AXI4-Lite responder (slave) holding the UDP filter's control/status registers. It is the far end of the config-write path driven by the init/host AXI4-Lite master. It exposes registered configuration outputs to the filter datapath and counts filter match/drop events. Single clock domain, no read-side effects except where noted.

Parameters:
ADDR_W, 12, byte-address width of s_axi_awaddr/s_axi_araddr; decode uses bits [ADDR_W-1:2]
ID_VALUE, 32'h5544_5046, constant returned by ID register

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte-lane enables
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
match_pulse  in  1  one-cycle pulse per matched packet
drop_pulse  in  1  one-cycle pulse per dropped packet
cfg_filter_en  out  1  CTRL[0]
cfg_dst_port  out  16  DST_PORT[15:0]
cfg_src_ip  out  32  SRC_IP
cfg_src_mask  out  32  SRC_MASK

Behaviour:
- Register map (byte offset): 0x00 CTRL RW ([0] filter_en; [1] cnt_clr, write-1 self-clearing, reads 0); 0x04 DST_PORT RW [15:0], upper bits read 0; 0x08 SRC_IP RW; 0x0C SRC_MASK RW; 0x10 MATCH_CNT RO; 0x14 DROP_CNT RO; 0x18 ID RO = ID_VALUE. addr[1:0] ignored.
- Reset (rst=1 at posedge): all RW registers, counters, and cfg_* = 0; awready=wready=arready=0 during reset; bvalid=rvalid=0; bresp=rresp=0; rdata=0; any latched AW/W/AR is discarded. The cycle after reset deasserts: awready=wready=arready=1.
- Write path: AW and W are accepted independently, in either order, each into a one-entry holding register. awready=1 only while no AW is held and bvalid=0; likewise wready for W. On the edge where both are held (including when both are accepted on the same edge), the next edge commits the write and raises bvalid. Write-to-bvalid latency: 1 cycle after the second handshake. bvalid holds with bresp stable until bready; both ready signals reassert on the cycle after the B handshake. One outstanding write.
- wstrb honoured per byte on RW registers. Writes to RO offsets are ignored, bresp=OKAY(2'b00). Unmapped offsets: no effect, bresp=SLVERR(2'b10).
- cnt_clr=1 (with wstrb[0]=1) zeroes both counters at commit; cnt_clr is never stored.
- Read path: arready = !rvalid. On AR handshake, rdata/rresp are registered and rvalid=1 on the next edge. Data is held stable until rready. Unmapped offsets: rdata=0, rresp=SLVERR.
- Read/write same edge: a read samples register contents before the commit on that edge (returns old value).
- Counters: +1 on the pulse, saturating at 32'hFFFF_FFFF. A clear on the same edge as a pulse wins, giving 0. match_pulse and drop_pulse are independent.
- cfg_* outputs are driven directly from registers, so a change is visible 1 cycle after write commit.

Decomposition:
- Package udp_filter_csr_pkg: register offsets, RESP_OKAY/RESP_SLVERR, CTRL bit indices, default ID_VALUE.
- Sub-module sat_counter32 (clk, rst, clr, inc, count), instantiated twice for MATCH_CNT and DROP_CNT.

Test Plan:
- Reset, then read 0x18 -> rdata=32'h5544_5046, rresp=0; read 0x00 -> 0; all cfg_* = 0.
- W accepted 3 cycles before AW, addr 0x08, data 32'hC0A8_0001, wstrb=4'hF -> bvalid 1 cycle after AW handshake, bresp=0, cfg_src_ip=32'hC0A8_0001.
- Write 0x04 data 32'hFFFF_1234 with wstrb=4'b0001 over prior value 0 -> cfg_dst_port=16'h0034; a readback returns 32'h0000_0034.
- 5 match_pulse, then write CTRL=32'h2 on the same edge as a 6th pulse -> MATCH_CNT reads 0. CTRL reads 0.
- Write to 0x40 -> bresp=2'b10, no register changes. Read 0x40 -> rdata=0, rresp=2'b10. Hold bready/rready low 4 cycles -> valid and data stay stable, awready/arready stay 0.
- Assert rst while AW is held and bvalid is pending -> bvalid=0 next cycle, no register is written, and the next transaction completes normally.

Source files
------------

// File: rtl/udp_filter_csr_slave_pkg.sv
// Shared definitions for the UDP filter CSR block: register offsets,
// AXI response codes, CTRL bit positions, write-FSM states and the
// byte-strobe merge helper.
package udp_filter_csr_pkg;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5544_5046;

    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Byte offsets of the register map
    localparam logic [7:0] OFF_CTRL      = 8'h00;
    localparam logic [7:0] OFF_DST_PORT  = 8'h04;
    localparam logic [7:0] OFF_SRC_IP    = 8'h08;
    localparam logic [7:0] OFF_SRC_MASK  = 8'h0C;
    localparam logic [7:0] OFF_MATCH_CNT = 8'h10;
    localparam logic [7:0] OFF_DROP_CNT  = 8'h14;
    localparam logic [7:0] OFF_ID        = 8'h18;

    localparam int unsigned CTRL_FILTER_EN = 0;
    localparam int unsigned CTRL_CNT_CLR   = 1;

    localparam logic [31:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_DST_PORT,
        SEL_SRC_IP,
        SEL_SRC_MASK,
        SEL_MATCH_CNT,
        SEL_DROP_CNT,
        SEL_ID,
        SEL_NONE
    } reg_sel_e;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_COMMIT,
        WR_RESP
    } wr_state_e;

    // Replace the byte lanes of cur selected by strb with those of wdata
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/udp_filter_csr_slave_if.sv
// AXI4-Lite bundle between the host/init master and the CSR slave.
// Signals keep their original s_axi_* names.
//   slave modport : address/data/valid/ready-from-master in, ready/resp/data out
//   master modport: the mirror image
interface udp_filter_csr_slave_if
    import udp_filter_csr_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) ();
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    resp_t             s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    resp_t             s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/udp_filter_csr_slave_sat_counter32.sv
// 32-bit event counter that sticks at all-ones.
//   clk, rst : core clock, synchronous active-high reset
//   clr      : zero the count; wins over a simultaneous inc
//   inc      : add one this cycle
//   count    : current value
module sat_counter32
    import udp_filter_csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/udp_filter_csr_slave.sv
// AXI4-Lite CSR slave for the UDP filter.
//   clk, rst      : core clock, synchronous active-high reset
//   axi           : AXI4-Lite slave port (udp_filter_csr_slave_if.slave)
//   match_pulse   : one-cycle pulse per matched packet
//   drop_pulse    : one-cycle pulse per dropped packet
//   cfg_filter_en : CTRL[0]
//   cfg_dst_port  : DST_PORT[15:0]
//   cfg_src_ip    : SRC_IP
//   cfg_src_mask  : SRC_MASK
module udp_filter_csr_slave
    import udp_filter_csr_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    udp_filter_csr_slave_if.slave axi,
    input  logic                 match_pulse,
    input  logic                 drop_pulse,
    output logic                 cfg_filter_en,
    output logic [15:0]          cfg_dst_port,
    output logic [31:0]          cfg_src_ip,
    output logic [31:0]          cfg_src_mask
);

    // Clears on reset, so every ready stays low through reset and
    // rises only on the first cycle after it.
    logic        out_of_reset;

    wr_state_e   wr_state, wr_next;
    logic        aw_rdy, w_rdy, bvalid_c, commit;
    logic        aw_hs, w_hs, ar_hs, ar_rdy;

    logic [ADDR_W-1:0] aw_addr;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    resp_t             bresp_q;

    logic        rvalid_q;
    logic [31:0] rdata_q;
    resp_t       rresp_q;

    reg_sel_e    wr_sel, rd_sel;
    logic [15:0] dst_merged;
    logic [31:0] ip_merged, mask_merged;
    logic [31:0] rd_data;
    resp_t       rd_resp;

    logic        cnt_clr;
    logic [31:0] match_cnt, drop_cnt;

    // addr[1:0] are masked off so sub-word addresses alias to their word
    function automatic reg_sel_e decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word;
        word = addr & ~ADDR_W'(3);
        if (word == ADDR_W'(OFF_CTRL))      return SEL_CTRL;
        if (word == ADDR_W'(OFF_DST_PORT))  return SEL_DST_PORT;
        if (word == ADDR_W'(OFF_SRC_IP))    return SEL_SRC_IP;
        if (word == ADDR_W'(OFF_SRC_MASK))  return SEL_SRC_MASK;
        if (word == ADDR_W'(OFF_MATCH_CNT)) return SEL_MATCH_CNT;
        if (word == ADDR_W'(OFF_DROP_CNT))  return SEL_DROP_CNT;
        if (word == ADDR_W'(OFF_ID))        return SEL_ID;
        return SEL_NONE;
    endfunction

    // ---------------- write channel FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    // AW and W are each parked in a one-entry holder; COMMIT is the single
    // cycle where both are present and the register write takes effect.
    always_comb begin
        wr_next  = wr_state;
        aw_rdy   = 1'b0;
        w_rdy    = 1'b0;
        bvalid_c = 1'b0;
        commit   = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                aw_rdy = out_of_reset;
                w_rdy  = out_of_reset;
                if (aw_rdy && axi.s_axi_awvalid && w_rdy && axi.s_axi_wvalid) begin
                    wr_next = WR_COMMIT;
                end else if (aw_rdy && axi.s_axi_awvalid) begin
                    wr_next = WR_HAVE_AW;
                end else if (w_rdy && axi.s_axi_wvalid) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                w_rdy = 1'b1;
                if (axi.s_axi_wvalid) wr_next = WR_COMMIT;
            end
            WR_HAVE_W: begin
                aw_rdy = 1'b1;
                if (axi.s_axi_awvalid) wr_next = WR_COMMIT;
            end
            WR_COMMIT: begin
                commit  = 1'b1;
                wr_next = WR_RESP;
            end
            WR_RESP: begin
                bvalid_c = 1'b1;
                if (axi.s_axi_bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    assign aw_hs  = aw_rdy && axi.s_axi_awvalid;
    assign w_hs   = w_rdy && axi.s_axi_wvalid;
    assign ar_rdy = out_of_reset && !rvalid_q;
    assign ar_hs  = ar_rdy && axi.s_axi_arvalid;

    // ---------------- write data merge / decode ----------------
    always_comb begin
        wr_sel      = decode(aw_addr);
        dst_merged  = {w_strb[1] ? w_data[15:8] : cfg_dst_port[15:8],
                       w_strb[0] ? w_data[7:0]  : cfg_dst_port[7:0]};
        ip_merged   = apply_wstrb(cfg_src_ip, w_data, w_strb);
        mask_merged = apply_wstrb(cfg_src_mask, w_data, w_strb);
    end

    // cnt_clr acts only at commit and is never stored
    assign cnt_clr = commit && (wr_sel == SEL_CTRL) && w_strb[0] && w_data[CTRL_CNT_CLR];

    // ---------------- read mux ----------------
    always_comb begin
        rd_sel  = decode(axi.s_axi_araddr);
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            SEL_CTRL:      rd_data[CTRL_FILTER_EN] = cfg_filter_en;
            SEL_DST_PORT:  rd_data[15:0] = cfg_dst_port;
            SEL_SRC_IP:    rd_data = cfg_src_ip;
            SEL_SRC_MASK:  rd_data = cfg_src_mask;
            SEL_MATCH_CNT: rd_data = match_cnt;
            SEL_DROP_CNT:  rd_data = drop_cnt;
            SEL_ID:        rd_data = ID_VALUE;
            default:       rd_resp = RESP_SLVERR;
        endcase
    end

    // ---------------- holders, registers, read response ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_of_reset  <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            bresp_q       <= RESP_OKAY;
            cfg_filter_en <= 1'b0;
            cfg_dst_port  <= '0;
            cfg_src_ip    <= '0;
            cfg_src_mask  <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
        end else begin
            out_of_reset <= 1'b1;
            if (aw_hs) aw_addr <= axi.s_axi_awaddr;
            if (w_hs) begin
                w_data <= axi.s_axi_wdata;
                w_strb <= axi.s_axi_wstrb;
            end
            if (commit) begin
                bresp_q <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                case (wr_sel)
                    SEL_CTRL:     if (w_strb[0]) cfg_filter_en <= w_data[CTRL_FILTER_EN];
                    SEL_DST_PORT: cfg_dst_port <= dst_merged;
                    SEL_SRC_IP:   cfg_src_ip   <= ip_merged;
                    SEL_SRC_MASK: cfg_src_mask <= mask_merged;
                    default: ;
                endcase
            end
            // Sampling happens before this edge's commit lands, so a
            // same-edge read returns the pre-write value.
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && axi.s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign axi.s_axi_awready = aw_rdy;
    assign axi.s_axi_wready  = w_rdy;
    assign axi.s_axi_bvalid  = bvalid_c;
    assign axi.s_axi_bresp   = bresp_q;
    assign axi.s_axi_arready = ar_rdy;
    assign axi.s_axi_rvalid  = rvalid_q;
    assign axi.s_axi_rdata   = rdata_q;
    assign axi.s_axi_rresp   = rresp_q;

    sat_counter32 u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (match_pulse),
        .count (match_cnt)
    );

    sat_counter32 u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (drop_pulse),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_udp_filter_csr_slave.sv
// Self-checking bench for udp_filter_csr_slave: directed scenarios followed
// by randomized AXI-Lite traffic and event pulses, checked against a
// register-map model held in plain variables.
module tb_udp_filter_csr_slave;
    import udp_filter_csr_pkg::*;

    localparam int unsigned AW     = 12;
    localparam logic [31:0] ID_VAL = 32'h5544_5046;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        match_pulse = 1'b0;
    logic        drop_pulse  = 1'b0;
    logic        cfg_filter_en;
    logic [15:0] cfg_dst_port;
    logic [31:0] cfg_src_ip, cfg_src_mask;

    udp_filter_csr_slave_if #(.ADDR_W(AW)) axi ();

    udp_filter_csr_slave #(.ADDR_W(AW), .ID_VALUE(ID_VAL)) dut (
        .clk           (clk),
        .rst           (rst),
        .axi           (axi),
        .match_pulse   (match_pulse),
        .drop_pulse    (drop_pulse),
        .cfg_filter_en (cfg_filter_en),
        .cfg_dst_port  (cfg_dst_port),
        .cfg_src_ip    (cfg_src_ip),
        .cfg_src_mask  (cfg_src_mask)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic        m_en    = 1'b0;
    logic [15:0] m_dst   = '0;
    logic [31:0] m_ip    = '0;
    logic [31:0] m_mask  = '0;
    logic [31:0] m_match = '0;
    logic [31:0] m_drop  = '0;
    bit          clr_pending = 1'b0;
    bit          rand_pulses = 1'b0;
    logic [31:0] last_rdata  = '0;

    logic [AW-1:0] addr_tab [10] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                                     12'h014, 12'h018, 12'h01C, 12'h040, 12'h100};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] m;
        m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (cur & ~m) | (data & m);
    endfunction

    function automatic logic [31:0] m_read(input logic [AW-1:0] addr, output logic [1:0] resp);
        logic [AW-1:0] off;
        logic [31:0]   v;
        off  = addr & ~AW'(3);
        v    = '0;
        resp = 2'b00;
        case (off)
            12'h000: v = {31'd0, m_en};
            12'h004: v = {16'd0, m_dst};
            12'h008: v = m_ip;
            12'h00C: v = m_mask;
            12'h010: v = m_match;
            12'h014: v = m_drop;
            12'h018: v = ID_VAL;
            default: resp = 2'b10;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] m_write(input logic [AW-1:0] addr, input logic [31:0] data,
                                           input logic [3:0] strb);
        logic [AW-1:0] off;
        logic [31:0]   cur;
        logic [1:0]    resp;
        off  = addr & ~AW'(3);
        resp = 2'b00;
        case (off)
            12'h000: if (strb[0]) begin
                m_en = data[0];
                if (data[1]) clr_pending = 1'b1;
            end
            12'h004: begin
                cur   = merge({16'd0, m_dst}, data, strb);
                m_dst = cur[15:0];
            end
            12'h008: m_ip   = merge(m_ip, data, strb);
            12'h00C: m_mask = merge(m_mask, data, strb);
            12'h010, 12'h014, 12'h018: ;
            default: resp = 2'b10;
        endcase
        return resp;
    endfunction

    // One clock: advance the model for this edge, then drive the next pulses
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_en = 1'b0; m_dst = '0; m_ip = '0; m_mask = '0; m_match = '0; m_drop = '0;
        end else if (clr_pending) begin
            m_match = '0;
            m_drop  = '0;
        end else begin
            if (match_pulse && m_match != 32'hFFFF_FFFF) m_match = m_match + 32'd1;
            if (drop_pulse  && m_drop  != 32'hFFFF_FFFF) m_drop  = m_drop + 32'd1;
        end
        clr_pending = 1'b0;
        #1;
        if (rand_pulses) begin
            match_pulse = 1'($urandom_range(0, 1));
            drop_pulse  = 1'($urandom_range(0, 1));
        end else begin
            match_pulse = 1'b0;
            drop_pulse  = 1'b0;
        end
    endtask

    task automatic check_cfg();
        check_eq("cfg_filter_en", 32'(cfg_filter_en), 32'(m_en));
        check_eq("cfg_dst_port",  32'(cfg_dst_port),  32'(m_dst));
        check_eq("cfg_src_ip",    cfg_src_ip,   m_ip);
        check_eq("cfg_src_mask",  cfg_src_mask, m_mask);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int unsigned aw_dly,
                             input int unsigned w_dly, input int unsigned b_dly,
                             input bit pulse_at_commit);
        bit          aw_done = 1'b0;
        bit          w_done  = 1'b0;
        bit          hs_aw, hs_w;
        logic [1:0]  exp_resp;
        int unsigned cyc = 0;
        axi.s_axi_awaddr = addr;
        axi.s_axi_wdata  = data;
        axi.s_axi_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            axi.s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            axi.s_axi_wvalid  = !w_done && (cyc >= w_dly);
            hs_aw = axi.s_axi_awvalid && axi.s_axi_awready;
            hs_w  = axi.s_axi_wvalid && axi.s_axi_wready;
            tick();
            aw_done |= hs_aw;
            w_done  |= hs_w;
            cyc++;
        end
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        check_eq("wr_handshake", 32'({aw_done, w_done}), 32'd3);
        if (!(aw_done && w_done)) return;
        check_eq("bvalid_early", 32'(axi.s_axi_bvalid), 32'd0);
        exp_resp = m_write(addr, data, strb);
        if (pulse_at_commit) match_pulse = 1'b1;
        tick();
        check_eq("bvalid", 32'(axi.s_axi_bvalid), 32'd1);
        check_eq("bresp",  32'(axi.s_axi_bresp),  32'(exp_resp));
        axi.s_axi_bready = 1'b0;
        repeat (b_dly) begin
            tick();
            check_eq("bvalid_hold",  32'(axi.s_axi_bvalid),  32'd1);
            check_eq("bresp_hold",   32'(axi.s_axi_bresp),   32'(exp_resp));
            check_eq("awready_busy", 32'(axi.s_axi_awready), 32'd0);
            check_eq("wready_busy",  32'(axi.s_axi_wready),  32'd0);
        end
        axi.s_axi_bready = 1'b1;
        tick();
        axi.s_axi_bready = 1'b0;
        check_eq("bvalid_done",  32'(axi.s_axi_bvalid),  32'd0);
        check_eq("awready_back", 32'(axi.s_axi_awready), 32'd1);
        check_eq("wready_back",  32'(axi.s_axi_wready),  32'd1);
        check_cfg();
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int unsigned ar_dly,
                            input int unsigned r_dly);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit          done = 1'b0;
        int unsigned cyc  = 0;
        exp_data = '0;
        exp_resp = '0;
        axi.s_axi_araddr = addr;
        repeat (ar_dly) tick();
        while (!done && cyc < 20) begin
            axi.s_axi_arvalid = 1'b1;
            if (axi.s_axi_arready) begin
                exp_data = m_read(addr, exp_resp);
                done     = 1'b1;
            end
            tick();
            cyc++;
        end
        axi.s_axi_arvalid = 1'b0;
        check_eq("rd_handshake", 32'(done), 32'd1);
        if (!done) return;
        check_eq("rvalid", 32'(axi.s_axi_rvalid), 32'd1);
        check_eq("rdata",  axi.s_axi_rdata, exp_data);
        check_eq("rresp",  32'(axi.s_axi_rresp), 32'(exp_resp));
        last_rdata = axi.s_axi_rdata;
        axi.s_axi_rready = 1'b0;
        repeat (r_dly) begin
            tick();
            check_eq("rvalid_hold",  32'(axi.s_axi_rvalid),  32'd1);
            check_eq("rdata_hold",   axi.s_axi_rdata, exp_data);
            check_eq("rresp_hold",   32'(axi.s_axi_rresp),   32'(exp_resp));
            check_eq("arready_busy", 32'(axi.s_axi_arready), 32'd0);
        end
        axi.s_axi_rready = 1'b1;
        tick();
        axi.s_axi_rready = 1'b0;
        check_eq("rvalid_done",  32'(axi.s_axi_rvalid),  32'd0);
        check_eq("arready_back", 32'(axi.s_axi_arready), 32'd1);
    endtask

    task automatic do_reset(input int unsigned cycles);
        rst = 1'b1;
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
        axi.s_axi_bready  = 1'b0; axi.s_axi_rready = 1'b0;
        repeat (cycles) tick();
        check_eq("rst_awready", 32'(axi.s_axi_awready), 32'd0);
        check_eq("rst_wready",  32'(axi.s_axi_wready),  32'd0);
        check_eq("rst_arready", 32'(axi.s_axi_arready), 32'd0);
        check_eq("rst_bvalid",  32'(axi.s_axi_bvalid),  32'd0);
        check_eq("rst_rvalid",  32'(axi.s_axi_rvalid),  32'd0);
        check_eq("rst_bresp",   32'(axi.s_axi_bresp),   32'd0);
        check_eq("rst_rresp",   32'(axi.s_axi_rresp),   32'd0);
        check_eq("rst_rdata",   axi.s_axi_rdata, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_awready", 32'(axi.s_axi_awready), 32'd1);
        check_eq("post_rst_wready",  32'(axi.s_axi_wready),  32'd1);
        check_eq("post_rst_arready", 32'(axi.s_axi_arready), 32'd1);
        check_cfg();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    s;
        logic [1:0]    dummy;
        int unsigned   pick;

        axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata  = '0; axi.s_axi_wstrb   = '0; axi.s_axi_wvalid = 1'b0;
        axi.s_axi_bready = 1'b0;
        axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;

        // reset and identification
        do_reset(3);
        axi_read(12'h018, 0, 0);
        check_eq("id_value", last_rdata, 32'h5544_5046);
        axi_read(12'h000, 0, 0);
        check_eq("ctrl_after_reset", last_rdata, 32'd0);
        check_eq("src_ip_after_reset", cfg_src_ip, 32'd0);

        // W leads AW by three cycles
        axi_write(12'h008, 32'hC0A8_0001, 4'hF, 3, 0, 0, 1'b0);
        check_eq("src_ip_value", cfg_src_ip, 32'hC0A8_0001);

        // partial strobe on DST_PORT
        axi_write(12'h004, 32'hFFFF_1234, 4'b0001, 0, 0, 0, 1'b0);
        check_eq("dst_port_lane0", 32'(cfg_dst_port), 32'h0000_0034);
        axi_read(12'h004, 0, 0);
        check_eq("dst_port_readback", last_rdata, 32'h0000_0034);

        // counter clear racing a match pulse
        repeat (5) begin
            match_pulse = 1'b1;
            tick();
        end
        axi_read(12'h010, 0, 0);
        check_eq("match_cnt_five", last_rdata, 32'd5);
        axi_write(12'h000, 32'h0000_0002, 4'hF, 0, 0, 0, 1'b1);
        axi_read(12'h010, 0, 0);
        check_eq("match_cnt_cleared", last_rdata, 32'd0);
        axi_read(12'h000, 0, 0);
        check_eq("ctrl_clr_reads0", last_rdata, 32'd0);

        // unmapped accesses with stalled responses
        axi_write(12'h040, 32'hA5A5_5A5A, 4'hF, 0, 0, 4, 1'b0);
        axi_read(12'h040, 0, 4);
        check_eq("unmapped_rdata", last_rdata, 32'd0);
        axi_read(12'h01E, 1, 2);

        // saturation at all-ones
        force dut.u_match_cnt.count = 32'hFFFF_FFFE;
        tick();
        release dut.u_match_cnt.count;
        m_match = 32'hFFFF_FFFE;
        axi_read(12'h010, 0, 0);
        match_pulse = 1'b1; tick();
        match_pulse = 1'b1; tick();
        match_pulse = 1'b1; tick();
        axi_read(12'h010, 0, 0);
        check_eq("match_cnt_saturated", last_rdata, 32'hFFFF_FFFF);

        // reset while an AW is held: the held address must be dropped
        axi_write(12'h00C, 32'h0F0F_0F0F, 4'hF, 0, 0, 0, 1'b0);
        axi.s_axi_awaddr  = 12'h00C;
        axi.s_axi_awvalid = 1'b1;
        check_eq("aw_accept_ready", 32'(axi.s_axi_awready), 32'd1);
        tick();
        axi.s_axi_awvalid = 1'b0;
        check_eq("aw_held_awready", 32'(axi.s_axi_awready), 32'd0);
        check_eq("aw_held_wready",  32'(axi.s_axi_wready),  32'd1);
        axi.s_axi_wdata  = 32'hDEAD_BEEF;
        axi.s_axi_wstrb  = 4'hF;
        axi.s_axi_wvalid = 1'b1;
        rst = 1'b1;
        tick();
        axi.s_axi_wvalid = 1'b0;
        check_eq("rst_held_bvalid", 32'(axi.s_axi_bvalid), 32'd0);
        rst = 1'b0;
        tick();
        repeat (2) tick();
        check_eq("rst_held_no_commit", 32'(axi.s_axi_bvalid), 32'd0);
        check_cfg();
        axi_write(12'h00C, 32'h1234_5678, 4'hF, 1, 0, 0, 1'b0);
        axi_read(12'h00C, 0, 0);

        // reset while bvalid is pending
        axi.s_axi_awaddr  = 12'h008;
        axi.s_axi_wdata   = 32'h0A0B_0C0D;
        axi.s_axi_wstrb   = 4'hF;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        tick();
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        dummy = m_write(12'h008, 32'h0A0B_0C0D, 4'hF);
        tick();
        check_eq("pend_bvalid", 32'(axi.s_axi_bvalid), 32'd1);
        check_eq("pend_bresp",  32'(axi.s_axi_bresp),  32'(dummy));
        rst = 1'b1;
        tick();
        check_eq("pend_bvalid_dropped", 32'(axi.s_axi_bvalid), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("pend_awready_back", 32'(axi.s_axi_awready), 32'd1);
        check_cfg();
        axi_write(12'h000, 32'h0000_0001, 4'h1, 0, 2, 1, 1'b0);
        axi_read(12'h000, 0, 1);

        // randomized traffic with free-running pulses
        rand_pulses = 1'b1;
        for (int i = 0; i < 160; i++) begin
            pick = $urandom_range(0, 9);
            a    = addr_tab[pick] | AW'($urandom_range(0, 3));
            d    = $urandom;
            s    = 4'($urandom_range(0, 15));
            if (pick == 0 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2),
                          $urandom_range(0, 2), 1'b0);
            end else begin
                axi_read(a, $urandom_range(0, 1), $urandom_range(0, 2));
            end
        end
        rand_pulses = 1'b0;
        tick();
        axi_read(12'h014, 0, 0);
        axi_read(12'h010, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
